// File: rtl/cpu_pkg.sv
// Shared state encoding and default sizing for the boot loader and its run monitor.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_HOLD    = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_e;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_HOLD_CYCLES = 4;
  localparam int DEF_MAX_CYCLES  = 1000;

endpackage

// File: rtl/boot_loader_if.sv
// Program-word stream into the loader and instruction-memory write port out of it.
interface boot_loader_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;

  // master is the program source / memory sink; slave is the loader
  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/boot_loader_run_monitor.sv
// RUN-phase cycle counter with halt / budget-exhausted decisions (decisions are combinational
// from the registered count, so the count seen in the Nth RUN cycle is N).
module run_monitor
  import cpu_pkg::*;
#(
  parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        start_run,
  input  logic        in_run,
  input  logic        cpu_halt,
  output logic [31:0] cycle_count,
  output logic        halt_hit,
  output logic        budget_hit
);

  logic [31:0] count_q, count_d;

  // halt beats budget when both land in the same cycle
  assign halt_hit   = in_run && cpu_halt;
  assign budget_hit = in_run && !cpu_halt && (count_q >= 32'(MAX_CYCLES));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (start_run || (in_run && !halt_hit && !budget_hit)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign cycle_count = count_q;

endmodule

// File: rtl/boot_loader.sv
// Loads a program stream into instruction memory, holds the CPU in reset for HOLD_CYCLES,
// then releases it and reports halt (done) or budget exhaustion (timeout).
module boot_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int MAX_CYCLES  = DEF_MAX_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  boot_loader_if.slave      bus,
  output logic              cpu_reset,
  input  logic              cpu_halt,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       cycle_count,
  output logic [ADDR_W:0]   word_count
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic handshake;
  logic mem_full;
  logic hold_last;
  logic load_enter;
  logic halt_hit;
  logic budget_hit;

  assign handshake  = bus.in_valid && (state_q == ST_LOAD);
  // the word being accepted now occupies the last memory location
  assign mem_full   = &word_count_q[ADDR_W-1:0];
  assign hold_last  = (state_q == ST_HOLD) && (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1));
  assign load_enter = (state_d == ST_LOAD) && (state_q != ST_LOAD);

  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    hold_cnt_d   = hold_cnt_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (start) begin
          state_d      = ST_LOAD;
          word_count_d = '0;
        end
      end
      ST_LOAD: begin
        if (handshake) begin
          we_d         = 1'b1;
          addr_d       = word_count_q[ADDR_W-1:0];
          wdata_d      = bus.in_data;
          word_count_d = word_count_q + (ADDR_W+1)'(1);
          if (bus.in_last || mem_full) begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
          end
        end
      end
      ST_HOLD: begin
        if (hold_last) begin
          state_d = ST_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (halt_hit) begin
          state_d = ST_DONE;
        end else if (budget_hit) begin
          state_d = ST_TIMEOUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // reset also drops any write registered on the reset edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      word_count_q <= '0;
      hold_cnt_q   <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      hold_cnt_q   <= hold_cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  run_monitor #(
    .MAX_CYCLES (MAX_CYCLES)
  ) u_run_monitor (
    .clk         (clk),
    .reset       (reset),
    .clear       (load_enter),
    .start_run   (hold_last),
    .in_run      (state_q == ST_RUN),
    .cpu_halt    (cpu_halt),
    .cycle_count (cycle_count),
    .halt_hit    (halt_hit),
    .budget_hit  (budget_hit)
  );

  assign bus.in_ready   = (state_q == ST_LOAD);
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

  assign cpu_reset  = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_HOLD);
  assign done       = (state_q == ST_DONE);
  assign timeout    = (state_q == ST_TIMEOUT);
  assign word_count = word_count_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench: two loaders (8-bit/1000-cycle and 3-bit/20-cycle) share one stimulus stream.
module tb_boot_loader;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, in_valid, in_last, cpu_halt;
  logic [15:0] in_data;
  int          n_cmp = 0;
  int          n_err = 0;

  boot_loader_if #(.ADDR_W(8), .DATA_W(16)) ifa();
  boot_loader_if #(.ADDR_W(3), .DATA_W(16)) ifb();

  assign ifa.in_valid = in_valid;
  assign ifa.in_data  = in_data;
  assign ifa.in_last  = in_last;
  assign ifb.in_valid = in_valid;
  assign ifb.in_data  = in_data;
  assign ifb.in_last  = in_last;

  logic        a_cpu_reset, a_done, a_timeout;
  logic [31:0] a_cycle;
  logic [8:0]  a_word;
  logic        b_cpu_reset, b_done, b_timeout;
  logic [31:0] b_cycle;
  logic [3:0]  b_word;

  boot_loader #(.ADDR_W(8), .DATA_W(16), .HOLD_CYCLES(4), .MAX_CYCLES(1000)) dut_a (
    .clk(clk), .reset(reset), .start(start), .bus(ifa),
    .cpu_reset(a_cpu_reset), .cpu_halt(cpu_halt), .done(a_done), .timeout(a_timeout),
    .cycle_count(a_cycle), .word_count(a_word)
  );

  boot_loader #(.ADDR_W(3), .DATA_W(16), .HOLD_CYCLES(4), .MAX_CYCLES(20)) dut_b (
    .clk(clk), .reset(reset), .start(start), .bus(ifb),
    .cpu_reset(b_cpu_reset), .cpu_halt(cpu_halt), .done(b_done), .timeout(b_timeout),
    .cycle_count(b_cycle), .word_count(b_word)
  );

  logic [7:0]  la_addr [32];
  logic [15:0] la_data [32];
  int          la_n = 0;
  logic [7:0]  lb_addr [32];
  logic [15:0] lb_data [32];
  int          lb_n = 0;

  always @(negedge clk) begin
    if (ifa.imem_we === 1'b1 && la_n < 32) begin
      la_addr[la_n] = ifa.imem_addr;
      la_data[la_n] = ifa.imem_wdata;
      la_n++;
    end
    if (ifb.imem_we === 1'b1 && lb_n < 32) begin
      lb_addr[lb_n] = 8'(ifb.imem_addr);
      lb_data[lb_n] = ifb.imem_wdata;
      lb_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic v, input logic [15:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    tick();
  endtask

  task automatic wait_run_b();
    for (int i = 0; i < 20; i++) begin
      if (b_cpu_reset === 1'b0) break;
      tick();
    end
    chk("b_run_reached", 32'(b_cpu_reset), 32'd0);
  endtask

  bit          gv [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [15:0] gd [6] = '{16'h3000, 16'hDEAD, 16'h3001, 16'hBEEF, 16'hBEEF, 16'h3002};
  bit          gl [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; cpu_halt = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_cpu_reset", 32'(a_cpu_reset), 32'd1);
    chk("rst_in_ready", 32'(ifa.in_ready), 32'd0);
    chk("rst_we", 32'(ifa.imem_we), 32'd0);
    chk("rst_done_timeout", {a_done, a_timeout}, 32'd0);
    chk("rst_cycle", a_cycle, 32'd0);
    chk("rst_word", 32'(a_word), 32'd0);

    // five-word load, then 4 HOLD cycles
    la_n = 0;
    start = 1'b1; tick(); start = 1'b0;
    chk("load_in_ready", 32'(ifa.in_ready), 32'd1);
    for (int i = 0; i < 5; i++) send(1'b1, 16'h1000 + 16'(i), i == 4);
    in_valid = 1'b0; in_last = 1'b0;
    chk("load_word_count", 32'(a_word), 32'd5);
    chk("load_last_we", {ifa.imem_we, 7'd0, ifa.imem_addr, ifa.imem_wdata}, 32'h8004_1004);
    chk("hold_in_ready", 32'(ifa.in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("hold_cpu_reset", 32'(a_cpu_reset), 32'd1);
      tick();
    end
    chk("hold_cpu_reset4", 32'(a_cpu_reset), 32'd1);
    chk("hold_we_idle", 32'(ifa.imem_we), 32'd0);
    tick();
    chk("run_cpu_reset", 32'(a_cpu_reset), 32'd0);
    chk("run_first_cycle", a_cycle, 32'd1);
    chk("load_n_writes", 32'(la_n), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("load_addr", 32'(la_addr[i]), 32'(i));
      chk("load_data", 32'(la_data[i]), 32'h1000 + 32'(i));
    end

    // halt on the 12th RUN cycle
    repeat (10) tick();
    chk("run_cycle11", a_cycle, 32'd11);
    tick();
    cpu_halt = 1'b1;
    chk("run_cycle12", a_cycle, 32'd12);
    chk("run_not_done", 32'(a_done), 32'd0);
    tick();
    cpu_halt = 1'b0;
    chk("halt_done_timeout", {a_done, a_timeout}, 32'h2);
    chk("halt_cycle", a_cycle, 32'd12);
    repeat (3) tick();
    chk("halt_done_held", 32'(a_done), 32'd1);
    chk("halt_cycle_held", a_cycle, 32'd12);

    // reset in the middle of a load
    start = 1'b1; tick(); start = 1'b0;
    chk("reload_clears", {a_done, a_timeout, 30'(a_cycle)}, 32'd0);
    chk("reload_word", 32'(a_word), 32'd0);
    for (int i = 0; i < 3; i++) send(1'b1, 16'h2000 + 16'(i), 1'b0);
    chk("mid_load_we", 32'(ifa.imem_we), 32'd1);
    in_data = 16'h2003;
    reset = 1'b1; tick(); reset = 1'b0; in_valid = 1'b0;
    chk("mrst_cpu_reset", 32'(a_cpu_reset), 32'd1);
    chk("mrst_in_ready", 32'(ifa.in_ready), 32'd0);
    chk("mrst_we_addr_data", {ifa.imem_we, 7'd0, ifa.imem_addr, ifa.imem_wdata}, 32'd0);
    chk("mrst_flags", {a_done, a_timeout}, 32'd0);
    chk("mrst_counts", a_cycle | 32'(a_word), 32'd0);

    // reload from address 0 with a gapped stream
    la_n = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) send(gv[i], gd[i], gl[i]);
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    chk("gap_n_writes", 32'(la_n), 32'd3);
    chk("gap_word", 32'(a_word), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("gap_addr", 32'(la_addr[i]), 32'(i));
      chk("gap_data", 32'(la_data[i]), 32'h3000 + 32'(i));
    end

    // timeout on the 20-cycle loader
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    send(1'b1, 16'h5000, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    wait_run_b();
    chk("to_first_cycle", b_cycle, 32'd1);
    repeat (19) tick();
    chk("to_cycle20", b_cycle, 32'd20);
    chk("to_not_yet", 32'(b_timeout), 32'd0);
    tick();
    chk("to_flags", {b_done, b_timeout}, 32'h1);
    chk("to_cycle_frozen", b_cycle, 32'd20);
    repeat (3) tick();
    chk("to_held", {b_done, b_timeout, 30'(b_cycle)}, 32'd20 | 32'h4000_0000);
    start = 1'b1; tick(); start = 1'b0;
    chk("to_restart_clear", {b_done, b_timeout, 30'(b_cycle)}, 32'd0);
    chk("to_restart_ready", 32'(ifb.in_ready), 32'd1);

    // memory-full on the 3-bit loader: 9 words offered, 8 taken
    lb_n = 0;
    for (int i = 0; i < 9; i++) begin
      send(1'b1, 16'h4000 + 16'(i), 1'b0);
      if (i == 7) begin
        chk("full_in_ready", 32'(ifb.in_ready), 32'd0);
        chk("full_word", 32'(b_word), 32'd8);
        chk("full_hold", 32'(b_cpu_reset), 32'd1);
      end
    end
    in_valid = 1'b0;
    tick();
    chk("full_n_writes", 32'(lb_n), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("full_addr", 32'(lb_addr[i]), 32'(i));
      chk("full_data", 32'(lb_data[i]), 32'h4000 + 32'(i));
    end

    // halt and budget in the same cycle; halt outside RUN ignored
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    send(1'b1, 16'h6000, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    cpu_halt = 1'b1;
    tick();
    chk("hold_halt_ignored", {b_cpu_reset, b_done}, 32'h2);
    cpu_halt = 1'b0;
    wait_run_b();
    repeat (19) tick();
    chk("tie_cycle20", b_cycle, 32'd20);
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    chk("tie_flags", {b_done, b_timeout}, 32'h2);
    chk("tie_cycle", b_cycle, 32'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter ADDR_W, default 8: instruction-memory address width; depth = 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 16: instruction word width.
REQ-003 Parameter HOLD_CYCLES, default 4: cycles cpu_reset stays high after load completes.
REQ-004 Parameter MAX_CYCLES, default 1000: run-cycle budget before timeout.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse: begin load, sampled in IDLE, DONE or TIMEOUT.
REQ-008 in_valid  input  1  program word present.
REQ-009 in_data  input  DATA_W  program word.
REQ-010 in_last  input  1  marks final program word.
REQ-011 in_ready  output  1  loader accepts a word this cycle.
REQ-012 imem_we  output  1  instruction-memory write strobe.
REQ-013 imem_addr  output  ADDR_W  write address.
REQ-014 imem_wdata  output  DATA_W  write data.
REQ-015 cpu_reset  output  1  reset driven to the CPU under test.
REQ-016 cpu_halt  input  1  CPU has fetched HALT.
REQ-017 done  output  1  CPU halted within budget; held until next start.
REQ-018 timeout  output  1  budget exhausted without halt; held until next start.
REQ-019 cycle_count  output  32  run cycles elapsed in RUN.
REQ-020 word_count  output  ADDR_W+1  words written in current load.

Function
REQ-021 States SHALL be IDLE, LOAD, HOLD, RUN, DONE, TIMEOUT.
REQ-022 IDLE -> LOAD on start; DONE/TIMEOUT -> LOAD on start; start ignored in LOAD, HOLD and RUN.
REQ-023 Entering LOAD SHALL clear word_count, cycle_count, done, timeout.
REQ-024 in_ready SHALL be high only in LOAD; handshake = in_valid & in_ready.
REQ-025 Each handshake SHALL produce, next cycle, imem_we=1, imem_addr=word_count value at handshake, imem_wdata=in_data; imem_we=0 otherwise (write latency 1).
REQ-026 word_count SHALL increment by 1 per handshake.
REQ-027 LOAD -> HOLD on a handshake with in_last=1, or on the handshake of word 2**ADDR_W (memory full) regardless of in_last; no further words accepted.
REQ-028 cpu_reset SHALL be 1 in IDLE, LOAD, HOLD; 0 in RUN, DONE, TIMEOUT.
REQ-029 HOLD SHALL last exactly HOLD_CYCLES cycles, then -> RUN.
REQ-030 In RUN cycle_count SHALL increment by 1 every cycle, starting at 1 on the first RUN cycle.
REQ-031 RUN -> DONE when cpu_halt=1; cycle_count freezes at value that cycle; done=1 from next cycle.
REQ-032 RUN -> TIMEOUT when cycle_count reaches MAX_CYCLES with cpu_halt=0; timeout=1 from next cycle.
REQ-033 cpu_halt and budget exhaustion in the same cycle: DONE wins.
REQ-034 cpu_halt SHALL be ignored outside RUN.
REQ-035 done and timeout SHALL never be 1 simultaneously.

Reset
REQ-036 reset SHALL override all inputs, including mid-load and mid-run: state=IDLE, cpu_reset=1, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, done=0, timeout=0, cycle_count=0, word_count=0.
REQ-037 A write pending on the cycle reset is asserted SHALL be dropped.

Structure
REQ-038 State encoding enum and default parameter constants SHALL live in shared package cpu_pkg.
REQ-039 One sub-module, run_monitor (RUN-phase cycle counter plus halt/timeout decision), is natural; FSM, load path and HOLD counter stay in boot_loader.

Verification
REQ-040 start, 5 words 0x1000..0x1004 with in_last on 5th -> imem writes at addr 0..4, word_count=5, cpu_reset high 4 cycles more, then low.
REQ-041 Load then cpu_halt raised on 12th RUN cycle -> done=1, cycle_count=12, timeout=0.
REQ-042 MAX_CYCLES=20, cpu_halt never raised -> timeout=1, cycle_count=20, done=0.
REQ-043 ADDR_W=3, 9 words with in_last never set -> 8 writes (addr 0..7), in_ready low after 8th, HOLD entered.
REQ-044 reset pulsed during LOAD after 3 words -> all outputs at reset values next cycle; new start reloads from addr 0.
REQ-045 cpu_halt on the same cycle cycle_count reaches MAX_CYCLES -> done=1, timeout=0; in_valid toggling with gaps -> only handshake cycles written.
